dft_stream_generator: RTL and testbench



---
 rtl/dft_stream_generator.sv | 173 +++++++++++++++++
 tb/tb_dft_stream_generator.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dft_stream_generator.sv
// Streams windowed I/Q samples and per-bin oscillator values into the DFT
// accumulator, framing exactly one window per run with start/last strobes.
module dft_stream_generator #(
  parameter int IQ_WIDTH           = 16,
  parameter int WINDOW_WIDTH       = 16,
  parameter int OSC_WIDTH          = 27,
  parameter int NUM_BINS           = 16,
  parameter int SAMPLE_COUNT_WIDTH = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 run_i,
  input  logic [SAMPLE_COUNT_WIDTH-1:0]        num_samples_i,
  input  logic [NUM_BINS-1:0][OSC_WIDTH-1:0]   rot_real_i,
  input  logic [NUM_BINS-1:0][OSC_WIDTH-1:0]   rot_imag_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [IQ_WIDTH-1:0]                  in_i_i,
  input  logic [IQ_WIDTH-1:0]                  in_q_i,
  output logic                                 win_rd_o,
  output logic [SAMPLE_COUNT_WIDTH-1:0]        win_addr_o,
  input  logic [WINDOW_WIDTH-1:0]              win_data_i,
  output logic                                 start_o,
  output logic                                 sample_valid_o,
  output logic                                 last_sample_o,
  output logic [IQ_WIDTH-1:0]                  i_sample_o,
  output logic [IQ_WIDTH-1:0]                  q_sample_o,
  output logic [WINDOW_WIDTH-1:0]              window_coeff_o,
  output logic [NUM_BINS-1:0][OSC_WIDTH-1:0]   W_real_o,
  output logic [NUM_BINS-1:0][OSC_WIDTH-1:0]   W_imag_o,
  output logic                                 busy_o,
  output logic                                 done_o
);

  // state  | meaning
  // IDLE   | waiting for run_i with non-zero N
  // START  | one-cycle start strobe, oscillators reset to 1.0
  // RUN    | accepting samples until N have been taken
  // DRAIN  | waiting for the final sample (last_sample_o) to be emitted
  // GAP    | done_o pulse, lines up with the accumulator's DONE->IDLE
  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DRAIN, S_GAP} state_e;

  localparam int SCW  = SAMPLE_COUNT_WIDTH;
  localparam int FRAC = OSC_WIDTH - 2;
  localparam int PW   = 2 * OSC_WIDTH;
  localparam int AW   = PW + 1;

  localparam logic [SCW-1:0]          CNT_ONE = {{(SCW-1){1'b0}}, 1'b1};
  localparam logic [OSC_WIDTH-1:0]    FX_ONE  = {2'b01, {FRAC{1'b0}}};
  localparam logic signed [AW-1:0]    RND     = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [AW-1:0]    SAT_MAX = {{(AW-OSC_WIDTH+1){1'b0}}, {(OSC_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0]    SAT_MIN = {{(AW-OSC_WIDTH+1){1'b1}}, {(OSC_WIDTH-2){1'b0}}, 1'b1};

  state_e                               state_q, state_d;
  logic [SCW-1:0]                       n_q, cnt_q;
  logic                                 sv_q, last_q;
  logic [IQ_WIDTH-1:0]                  i_q, q_q;
  logic [WINDOW_WIDTH-1:0]              win_hold_q;
  logic [NUM_BINS-1:0][OSC_WIDTH-1:0]   w_cur_r_q, w_cur_i_q, w_out_r_q, w_out_i_q;
  logic [NUM_BINS-1:0][OSC_WIDTH-1:0]   w_nxt_r_d, w_nxt_i_d;
  logic                                 hs, run_ok, last_acc;

  // Complex multiply-accumulate term with round-half-up and symmetric saturation.
  function automatic logic [OSC_WIDTH-1:0] rot_mac(
    input logic signed [OSC_WIDTH-1:0] a, b, c, d,
    input logic                        neg
  );
    logic signed [PW-1:0] p1, p2;
    logic signed [AW-1:0] acc, sh;
    p1  = a * b;
    p2  = c * d;
    acc = neg ? (AW'(p1) - AW'(p2)) : (AW'(p1) + AW'(p2));
    sh  = (acc + RND) >>> FRAC;
    if (sh > SAT_MAX)      rot_mac = SAT_MAX[OSC_WIDTH-1:0];
    else if (sh < SAT_MIN) rot_mac = SAT_MIN[OSC_WIDTH-1:0];
    else                   rot_mac = sh[OSC_WIDTH-1:0];
  endfunction

  assign in_ready_o = (state_q == S_RUN) && (cnt_q < n_q);
  assign hs         = in_ready_o && in_valid_i;
  assign last_acc   = hs && (cnt_q == n_q - CNT_ONE);
  assign run_ok     = run_i && (num_samples_i != '0);

  // Next state and state-decoded strobes.
  always_comb begin
    state_d = state_q;
    start_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE:  if (run_ok) state_d = S_START;
      S_START: begin
        start_o = 1'b1;
        state_d = S_RUN;
      end
      S_RUN:   if (last_acc) state_d = S_DRAIN;
      S_DRAIN: if (last_q) state_d = S_GAP;
      S_GAP:   begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-bin recursive rotator: W_cur * rot_k.
  always_comb begin
    w_nxt_r_d = '0;
    w_nxt_i_d = '0;
    for (int k = 0; k < NUM_BINS; k++) begin
      w_nxt_r_d[k] = rot_mac(w_cur_r_q[k], rot_real_i[k], w_cur_i_q[k], rot_imag_i[k], 1'b1);
      w_nxt_i_d[k] = rot_mac(w_cur_r_q[k], rot_imag_i[k], w_cur_i_q[k], rot_real_i[k], 1'b0);
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Datapath: the accepted sample and the current oscillator go straight to
  // the output registers, so emission is exactly one cycle after acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_q        <= '0;
      cnt_q      <= '0;
      sv_q       <= 1'b0;
      last_q     <= 1'b0;
      i_q        <= '0;
      q_q        <= '0;
      win_hold_q <= '0;
      w_cur_r_q  <= '0;
      w_cur_i_q  <= '0;
      w_out_r_q  <= '0;
      w_out_i_q  <= '0;
    end else begin
      sv_q   <= hs;
      last_q <= last_acc;
      if (state_q == S_IDLE && run_ok) n_q <= num_samples_i;
      if (state_q == S_START) begin
        cnt_q <= '0;
        for (int k = 0; k < NUM_BINS; k++) begin
          w_cur_r_q[k] <= FX_ONE;
          w_cur_i_q[k] <= '0;
        end
      end else if (hs) begin
        cnt_q     <= cnt_q + CNT_ONE;
        i_q       <= in_i_i;
        q_q       <= in_q_i;
        w_out_r_q <= w_cur_r_q;
        w_out_i_q <= w_cur_i_q;
        w_cur_r_q <= w_nxt_r_d;
        w_cur_i_q <= w_nxt_i_d;
      end
      if (sv_q) win_hold_q <= win_data_i;
    end
  end

  // The coefficient memory answers one cycle after the read, i.e. in the
  // emission cycle itself, so it is passed through then and held afterwards.
  assign window_coeff_o = sv_q ? win_data_i : win_hold_q;

  assign win_rd_o       = hs;
  assign win_addr_o     = cnt_q;
  assign sample_valid_o = sv_q;
  assign last_sample_o  = last_q;
  assign i_sample_o     = i_q;
  assign q_sample_o     = q_q;
  assign W_real_o       = w_out_r_q;
  assign W_imag_o       = w_out_i_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_dft_stream_generator.sv
// Directed bench for dft_stream_generator: framing, handshake gaps, window
// alignment, rotator sequences, saturation, back-to-back restart and reset.
module tb_dft_stream_generator;
  localparam int IW = 16;
  localparam int WW = 16;
  localparam int OW = 27;
  localparam int NB = 16;
  localparam int SW = 16;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    run = 1'b0;
  logic [SW-1:0]           num = '0;
  logic [NB-1:0][OW-1:0]   rot_r = '0, rot_i = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [IW-1:0]           in_i = '0, in_q = '0;
  logic                    win_rd;
  logic [SW-1:0]           win_addr;
  logic [WW-1:0]           win_data = '0;
  logic                    start, sample_valid, last_sample, busy, done;
  logic [IW-1:0]           i_sample, q_sample;
  logic [WW-1:0]           window_coeff;
  logic [NB-1:0][OW-1:0]   w_real, w_imag;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_emit_cyc = 0;
  int exp_wr[8];
  int exp_wi[8];

  dft_stream_generator dut (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run), .num_samples_i(num),
    .rot_real_i(rot_r), .rot_imag_i(rot_i),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_i_i(in_i), .in_q_i(in_q),
    .win_rd_o(win_rd), .win_addr_o(win_addr), .win_data_i(win_data),
    .start_o(start), .sample_valid_o(sample_valid), .last_sample_o(last_sample),
    .i_sample_o(i_sample), .q_sample_o(q_sample), .window_coeff_o(window_coeff),
    .W_real_o(w_real), .W_imag_o(w_imag), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous coefficient memory: h[n] = 100 + n, one cycle latency.
  always @(posedge clk) if (win_rd) win_data <= 16'd100 + win_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_rot(input logic [OW-1:0] rr, input logic [OW-1:0] ri);
    for (int k = 0; k < NB; k++) begin
      rot_r[k] = rr;
      rot_i[k] = ri;
    end
  endtask

  task automatic set_exp(input int r0, i0, r1, i1, r2, i2, r3, i3);
    exp_wr[0] = r0; exp_wi[0] = i0;
    exp_wr[1] = r1; exp_wi[1] = i1;
    exp_wr[2] = r2; exp_wi[2] = i2;
    exp_wr[3] = r3; exp_wi[3] = i3;
  endtask

  // One full run. vpat bit j is in_valid_i on the j-th RUN-phase cycle.
  // Sample n carries I=10+n, Q=-5-n; cycles without valid drive junk data.
  task automatic do_run(input int n, input logic [15:0] vpat, input bit chained);
    int acc = 0;
    int emit = 0;
    int vi = 0;
    int budget;
    bit prev_hs = 1'b0;
    logic exp_rdy;
    logic [IW-1:0] ei, eq;
    logic [WW-1:0] ew;
    logic [OW-1:0] ewr, ewi;
    logic [SW-1:0] ea;

    run = 1'b1;
    num = 16'(n);
    @(posedge clk); #1;
    run = 1'b0;
    in_valid = 1'b1;
    in_i = 16'hDEAD;
    in_q = 16'hBEEF;
    @(negedge clk);
    check("start", start, 1);
    check("busy_start", busy, 1);
    check("ready_in_start", in_ready, 0);
    if (chained) check("restart_distance", cyc - last_emit_cyc, 3);

    budget = 4 * n + 8;
    while (emit < n && budget > 0) begin
      budget--;
      @(posedge clk); #1;
      in_valid = (vi < 16) ? vpat[vi] : 1'b1;
      vi++;
      in_i = in_valid ? 16'(10 + acc) : 16'hDEAD;
      in_q = in_valid ? 16'(-5 - acc) : 16'hBEEF;
      @(negedge clk);
      check("start_once", start, 0);
      if (prev_hs) begin
        ei  = 16'(10 + emit);
        eq  = 16'(-5 - emit);
        ew  = 16'(100 + emit);
        ewr = exp_wr[emit][OW-1:0];
        ewi = exp_wi[emit][OW-1:0];
        check("sample_valid", sample_valid, 1);
        check("i_sample", i_sample, ei);
        check("q_sample", q_sample, eq);
        check("window_coeff", window_coeff, ew);
        check("w_real_bin0", w_real[0], ewr);
        check("w_imag_bin0", w_imag[0], ewi);
        check("w_real_binlast", w_real[NB-1], ewr);
        check("last_sample", last_sample, (emit == n - 1));
        if (emit == n - 1) last_emit_cyc = cyc;
        emit++;
      end else begin
        check("sv_gap", sample_valid, 0);
      end
      exp_rdy = (acc < n);
      check("in_ready", in_ready, exp_rdy);
      prev_hs = in_valid && exp_rdy;
      check("win_rd", win_rd, prev_hs);
      if (prev_hs) begin
        ea = 16'(acc);
        check("win_addr", win_addr, ea);
        acc++;
      end
    end
    check("emitted_count", emit, n);

    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("done", done, 1);
    check("sv_after", sample_valid, 0);
    check("busy_gap", busy, 1);
    check("last_after", last_sample, 0);
    ei = 16'(10 + n - 1);
    check("hold_i", i_sample, ei);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_once", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_sv", sample_valid, 0);
    check("rst_w_real", w_real[0], 0);
    check("rst_w_imag", w_imag[0], 0);
    check("rst_i", i_sample, 0);
    check("rst_win", window_coeff, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity rotation, back-to-back samples.
    set_rot(27'd33554432, 27'd0);
    set_exp(33554432, 0, 33554432, 0, 33554432, 0, 33554432, 0);
    do_run(4, 16'hFFFF, 1'b0);

    // Quarter-turn rotation: 1, j, -1, -j.
    set_rot(27'd0, 27'd33554432);
    set_exp(33554432, 0, 0, 33554432, -33554432, 0, 0, -33554432);
    do_run(4, 16'hFFFF, 1'b0);

    // Valid toggling 1-0-1-0-1: gaps propagate, coefficients stay aligned.
    set_rot(27'd33554432, 27'd0);
    set_exp(33554432, 0, 33554432, 0, 33554432, 0, 33554432, 0);
    do_run(3, 16'hFFF5, 1'b0);

    // Gain of (2^26-1)/2^25: (2^51 - 2^25 + 2^24) >>> 25 = 2^26-1 after one
    // step, and every later product exceeds the positive limit.
    set_rot(27'd67108863, 27'd0);
    set_exp(33554432, 0, 67108863, 0, 67108863, 0, 67108863, 0);
    do_run(4, 16'hFFFF, 1'b0);

    // N=1, then a run requested on the first IDLE cycle.
    set_rot(27'd33554432, 27'd0);
    set_exp(33554432, 0, 33554432, 0, 33554432, 0, 33554432, 0);
    do_run(1, 16'hFFFF, 1'b0);
    do_run(2, 16'hFFFF, 1'b1);

    // N=0 request is ignored.
    run = 1'b1;
    num = '0;
    @(posedge clk); #1;
    run = 1'b0;
    @(negedge clk);
    check("n0_busy", busy, 0);
    check("n0_start", start, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("n0_busy_later", busy, 0);

    // Reset in the middle of an 8-sample run after 2 accepts.
    set_rot(27'd0, 27'd33554432);
    run = 1'b1;
    num = 16'd8;
    @(posedge clk); #1;
    run = 1'b0;
    in_valid = 1'b1;
    in_i = 16'h0055;
    in_q = 16'h0066;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("pre_rst_sv", sample_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sv", sample_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_i", i_sample, 0);
    check("mid_rst_w_imag", w_imag[0], 0);
    check("mid_rst_win", window_coeff, 0);
    check("mid_rst_last", last_sample, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_addr", win_addr, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_hold_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh run after reset starts W at 1.0 and address at 0.
    set_rot(27'd0, 27'd33554432);
    set_exp(33554432, 0, 0, 33554432, -33554432, 0, 0, -33554432);
    do_run(4, 16'hFFFF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
